fc_frame_sequencer: RTL and testbench
=====================================

# fc_frame_sequencer

Sequential front/back end for one combinational fully-connected neuron layer (IN parallel WIDTH-bit activations in, one ReLU'd accumulator out). It collects a serial activation stream with valid/ready into an IN-entry register vector and drives that vector onto the layer's `x` port. It waits a fixed settle interval, then captures the layer's `z` result. The result goes downstream as a valid/ready beat, both raw and requantized to WIDTH bits for the next layer.

## Interface

Parameters:
- `WIDTH`, 8: activation width (bits).
- `IN`, 128: activations per frame; must be ≥ 2.
- `ZW`, 22: width of layer result `z` (WIDTH*2 + adder-tree growth).
- `SETTLE`, 2: cycles allowed for the combinational layer to settle; must be ≥ 1.
- `SHIFT`, 4: right shift applied to `z` before saturation to WIDTH bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_valid`  in  1: input activation beat valid.
- `s_data`  in  WIDTH: activation value, unsigned.
- `s_last`  in  1: marks the final beat of a frame.
- `s_ready`  out  1: block accepts a beat this cycle.
- `x`  out  [WIDTH-1:0] x[0:IN-1]: registered activation vector to the layer.
- `z`  in  ZW: layer result; non-negative after ReLU, treated as unsigned.
- `m_valid`  out  1: result beat valid.
- `m_data`  out  ZW: captured raw `z`.
- `m_q`  out  WIDTH: requantized result.
- `m_ready`  in  1: downstream accepts the result.
- `frame_err`  out  1: one-cycle pulse on a framing error.

## Operation

- **States:** LOAD, WAIT, OUT. The state register and the index `idx` (clog2(IN) bits) reset to LOAD and 0.
- **LOAD** (`s_ready`=1):
  - Each accepted beat (`s_valid` && `s_ready`) writes `x[idx]` = `s_data` and increments `idx`.
  - Accept at `idx` < IN-1 with `s_last`=1: pulse `frame_err`, set `idx`←0, stay in LOAD. The frame is discarded and the `x` entries written so far are not cleared.
  - Accept at `idx` == IN-1: go to WAIT, clear the settle counter, set `idx`←0. If `s_last`=0 on this beat, pulse `frame_err`; the frame is still processed.
- **WAIT** (`s_ready`=0):
  - The settle counter counts 0..SETTLE-1. `x` is held constant.
  - On the edge ending count SETTLE-1: `m_data`←`z`, `m_q`←sat(`z` >> SHIFT), `m_valid`←1, go to OUT.
  - sat(v) = v if v < 2^WIDTH, else 2^WIDTH-1.
- **OUT** (`s_ready`=0, `m_valid`=1):
  - `m_data`/`m_q` are held stable until `m_valid` && `m_ready`.
  - On that handshake: `m_valid`←0, go to LOAD.
  - `m_data`/`m_q` keep their last value after the handshake.
- `x` is modified only by accepted LOAD beats.
- `s_valid` and `s_data` are ignored outside LOAD.
- `s_ready` is registered: `s_ready` ← (next_state == LOAD).

## Timing

- **Reset values** (asynchronous, immediate): `s_ready`=0, `m_valid`=0, `m_data`=0, `m_q`=0, `frame_err`=0, all `x[i]`=0, state LOAD, `idx`=0.
- `s_ready` rises in the first cycle after `rst_n` deasserts.
- Reset asserted mid-frame or in WAIT/OUT aborts all work; no partial result is ever emitted.
- **Latency:** if the last beat is accepted in cycle T, `s_ready`=0 from T+1, and `m_valid`=1 in cycle T+SETTLE+1 (T+3 by default).
- **Return to LOAD:** if the `m` handshake occurs in cycle H, `s_ready`=1 in H+1.
- **Minimum frame period:** IN + SETTLE + 1 cycles (131 by default) with `s_valid` and `m_ready` held high.
- **`frame_err` timing:** asserted for exactly the cycle after the offending accept.
- **`x` stability:** `x` is stable from T+1 until the next accepted LOAD beat.

## Test plan

1. **Reset:** drive `rst_n`=0 mid-LOAD at `idx`=40 → all outputs 0 and all `x` 0 immediately. After release, `s_ready`=1 next cycle, and a full 128-beat frame produces `m_valid` normally.
2. **Continuous frame:** `s_data` = i for beat i (i = 0..127), `s_last` on beat 127, `m_ready`=1, stub `z` = 22'd1000 → `x[i]` = i. `m_valid` at T+3 for one cycle with `m_data`=1000 and `m_q`=62; `s_ready` back high at T+4.
3. **Backpressure:** `m_ready`=0 for 10 cycles after `m_valid` rises, while `s_valid` is held high with changing data → `m_valid`, `m_data` and `m_q` stay stable, `s_ready`=0, no beats accepted, `x` unchanged. Release `m_ready` → one handshake, then LOAD.
4. **Early `s_last`:** `s_last` on beat 50 → `frame_err` pulses once and `idx` returns to 0. The next 128 clean beats yield exactly one result.
5. **Missing `s_last`:** no `s_last` on beat 127 → `frame_err` pulse, and the result is still emitted at T+3.
6. **Saturation:** stub `z` = 22'h3FFFF → `m_q`=255 and `m_data`=22'h3FFFF. Stub `z`=0 → `m_q`=0.

Source files
------------

// File: rtl/fc_frame_sequencer_if.sv
// Bundle of the activation stream, layer x/z ports and result stream
// around one fully-connected layer sequencer.
interface fc_frame_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int ZW    = 22
);
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] x [0:IN-1];
    logic [ZW-1:0]    z;
    logic             m_valid;
    logic [ZW-1:0]    m_data;
    logic [WIDTH-1:0] m_q;
    logic             m_ready;
    logic             frame_err;

    // master: the environment (source, layer stub, sink); slave: the sequencer
    modport master (
        output s_valid, s_data, s_last, z, m_ready,
        input  s_ready, x, m_valid, m_data, m_q, frame_err
    );
    modport slave (
        input  s_valid, s_data, s_last, z, m_ready,
        output s_ready, x, m_valid, m_data, m_q, frame_err
    );
endinterface

// File: rtl/fc_frame_sequencer.sv
// Collects a serial activation frame into the layer's x vector, waits for the
// combinational layer to settle, then emits raw and requantized z downstream.
module fc_frame_sequencer #(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int ZW     = 22,
    parameter int SETTLE = 2,
    parameter int SHIFT  = 4
) (
    input logic clk,
    input logic rst_n,
    fc_frame_sequencer_if.slave bus
);
    localparam int IW = $clog2(IN);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(IN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;

    state_t           state, next_state;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_q [IN];
    logic             s_ready, m_valid, frame_err;
    logic [ZW-1:0]    m_data;
    logic [WIDTH-1:0] m_q;

    logic             accept, at_last, capture;
    logic [ZW-1:0]    z_sh;
    logic [WIDTH-1:0] q_sat;

    assign accept  = (state == LOAD) && s_ready && bus.s_valid;
    assign at_last = (idx == IDX_LAST);
    assign capture = (state == WAIT) && (cnt == CNT_LAST);
    assign z_sh    = bus.z >> SHIFT;
    // Any bit above WIDTH after the shift means the value does not fit
    assign q_sat   = ((z_sh >> WIDTH) != '0) ? '1 : z_sh[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (accept && at_last)         next_state = WAIT;
            WAIT:    if (cnt == CNT_LAST)           next_state = OUT;
            OUT:     if (m_valid && bus.m_ready)    next_state = LOAD;
            default:                                next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_q       <= '0;
            frame_err <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            s_ready   <= (next_state == LOAD);
            // Early last discards the frame; missing last still processes it
            frame_err <= accept && (at_last ? !bus.s_last : bus.s_last);
            if (accept)
                idx <= (at_last || bus.s_last) ? '0 : idx + 1'b1;
            if (accept && at_last)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (capture) begin
                m_data  <= bus.z;
                m_q     <= q_sat;
                m_valid <= 1'b1;
            end else if (state == OUT && bus.m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) x_q[i] <= '0;
        end else begin
            for (int i = 0; i < IN; i++)
                if (accept && idx == IW'(i)) x_q[i] <= bus.s_data;
        end
    end

    assign bus.x         = x_q;
    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = m_data;
    assign bus.m_q       = m_q;
    assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_fc_frame_sequencer.sv
// Directed scoreboard bench: stimulus pushes expected results, a monitor pops
// and checks them as the sequencer presents them.
module tb_fc_frame_sequencer;
    localparam int WIDTH = 8, IN = 128, ZW = 22, SETTLE = 2, SHIFT = 4;

    typedef struct {
        logic [ZW-1:0]    d;
        logic [WIDTH-1:0] q;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_frame_sequencer_if #(.WIDTH(WIDTH), .IN(IN), .ZW(ZW)) bus ();
    fc_frame_sequencer #(.WIDTH(WIDTH), .IN(IN), .ZW(ZW), .SETTLE(SETTLE), .SHIFT(SHIFT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   ncmp = 0, nfail = 0;
    int   nres = 0, nerr = 0, err_cyc = -1;
    exp_t sb[$];
    logic [WIDTH-1:0] exp_x [IN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int x_mismatches();
        int n = 0;
        for (int i = 0; i < IN; i++) if (bus.x[i] !== exp_x[i]) n++;
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] pat(input int kind, input int i);
        case (kind)
            0:       return WIDTH'(i);
            1:       return WIDTH'(255 - i);
            2:       return WIDTH'(i * 3 + 7);
            default: return WIDTH'(i + 1);
        endcase
    endfunction

    // Monitor: checks result contents, latency, stability and return to LOAD
    logic mv_d = 1'b0;
    bit   hs_d = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mv_d = 1'b0;
            hs_d = 1'b0;
        end else begin
            if (hs_d) chk("s_ready_after_handshake", 32'(bus.s_ready), 32'd1);
            hs_d = 1'b0;
            if (bus.m_valid && !mv_d) begin
                chk("result_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("m_data", 32'(bus.m_data), 32'(sb[0].d));
                    chk("m_q", 32'(bus.m_q), 32'(sb[0].q));
                    chk("m_valid_latency", 32'(cyc), 32'(sb[0].due));
                end
            end
            if (bus.m_valid && bus.m_ready && sb.size() != 0) begin
                chk("m_data_at_handshake", 32'(bus.m_data), 32'(sb[0].d));
                chk("m_q_at_handshake", 32'(bus.m_q), 32'(sb[0].q));
                void'(sb.pop_front());
                nres++;
                hs_d = 1'b1;
            end
            mv_d = bus.m_valid;
            if (bus.frame_err) begin
                nerr++;
                err_cyc = cyc;
            end
        end
    end

    task automatic send_beat(input logic [WIDTH-1:0] d, input bit last, output int t);
        int k = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        t = -1;
        while (k < 50) begin
            @(negedge clk);
            if (bus.s_ready) begin
                t = cyc;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        if (t < 0) chk("beat_accept", 32'(k), 32'd0);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("result_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic send_frame(input int n, input int last_at, input int kind,
                              input logic [ZW-1:0] zv, input logic [ZW-1:0] ed,
                              input logic [WIDTH-1:0] eq, input bit exp_err,
                              input bit drain);
        int t = 0, err0 = nerr, res0 = nres;
        bus.z = zv;
        for (int i = 0; i < n; i++) begin
            send_beat(pat(kind, i), i == last_at, t);
            exp_x[i] = pat(kind, i);
            if (i == IN - 1) sb.push_back('{d: ed, q: eq, due: t + SETTLE + 1});
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(negedge clk);
        chk("s_ready_after_last", 32'(bus.s_ready), 32'(n != IN));
        @(posedge clk); #1;
        chk("frame_err_count", 32'(nerr - err0), 32'(exp_err));
        if (exp_err) chk("frame_err_cycle", 32'(err_cyc), 32'(t + 1));
        if (drain) begin
            wait_drain();
            chk("results_per_frame", 32'(nres - res0), 32'(n == IN));
            chk("x_contents", 32'(x_mismatches()), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, res0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        bus.z = '0; bus.m_ready = 1'b1;
        for (int i = 0; i < IN; i++) exp_x[i] = '0;

        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_m_q", 32'(bus.m_q), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("rst_x", 32'(x_mismatches()), 32'd0);
        @(posedge clk); #1; @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("s_ready_after_release", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;

        // Continuous frame: x[i]=i, 1000>>4 = 62
        send_frame(IN, IN - 1, 0, 22'd1000, 22'd1000, 8'd62, 1'b0, 1'b1);

        // Backpressure: 500>>4 = 31, held for 10 cycles with s_valid busy
        bus.m_ready = 1'b0;
        res0 = nres;
        send_frame(IN, IN - 1, 1, 22'd500, 22'd500, 8'd31, 1'b0, 1'b0);
        bus.s_valid = 1'b1;
        k = 0;
        while (!bus.m_valid && k < 20) begin
            bus.s_data = WIDTH'(k * 5 + 1);
            @(posedge clk); #1;
            k++;
        end
        chk("bp_m_valid_rise", 32'(bus.m_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            bus.s_data = WIDTH'(c * 17 + 3);
            bus.s_last = c[0];
            @(negedge clk);
            chk("bp_m_valid", 32'(bus.m_valid), 32'd1);
            chk("bp_m_data", 32'(bus.m_data), 32'd500);
            chk("bp_m_q", 32'(bus.m_q), 32'd31);
            chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("bp_x_unchanged", 32'(x_mismatches()), 32'd0);
        chk("bp_no_handshake", 32'(nres - res0), 32'd0);
        bus.m_ready = 1'b1;
        wait_drain();
        chk("bp_one_result", 32'(nres - res0), 32'd1);

        // Early s_last on beat 50, then a clean frame: 2000>>4 = 125
        send_frame(51, 50, 3, 22'd0, 22'd0, 8'd0, 1'b1, 1'b1);
        send_frame(IN, IN - 1, 2, 22'd2000, 22'd2000, 8'd125, 1'b0, 1'b1);

        // Missing s_last: result still emitted, 3000>>4 = 187
        send_frame(IN, -1, 0, 22'd3000, 22'd3000, 8'd187, 1'b1, 1'b1);

        // Saturation and zero
        send_frame(IN, IN - 1, 2, 22'h3FFFF, 22'h3FFFF, 8'd255, 1'b0, 1'b1);
        send_frame(IN, IN - 1, 1, 22'd0, 22'd0, 8'd0, 1'b0, 1'b1);

        // Reset mid-frame at idx 40
        send_frame(40, -1, 3, 22'd0, 22'd0, 8'd0, 1'b0, 1'b0);
        chk("pre_reset_x_written", 32'(x_mismatches()), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < IN; i++) exp_x[i] = '0;
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_m_data", 32'(bus.m_data), 32'd0);
        chk("midrst_m_q", 32'(bus.m_q), 32'd0);
        chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("midrst_x", 32'(x_mismatches()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("s_ready_after_midrst", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;
        // 160>>4 = 10
        send_frame(IN, IN - 1, 0, 22'd160, 22'd160, 8'd10, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
